up_data_framer: RTL
===================

Name: up_data_framer

Overview:
- Downstream stage of the 4-channel FIFO aggregator. Runs in the `fifo_rdclk` domain.
- Accepts the aggregator's `data_valid`/`up_data` 64-bit word stream, which has no backpressure, and buffers it in an internal word FIFO.
- Packs buffered words into byte-serial frames with header, sequence number and checksum, for the upload link (UART/Ethernet byte interface) with valid/ready handshake.
- Sends a short frame on timeout so that low-rate channels are not stalled.

Parameters:
- `DEPTH`, 16: internal word FIFO depth, in 64-bit words. Power of 2, ≥ `WORDS_PER_FRAME`.
- `WORDS_PER_FRAME`, 4: payload words in a full frame. Range 1..255.
- `TIMEOUT`, 1000: idle cycles with a partial buffer before a short frame is forced. ≥ 2.

Ports:
- `fifo_rdclk`  in  1  single clock for the whole block.
- `rst`  in  1  reset. Synchronous, active-high.
- `data_valid`  in  1  `up_data` qualifier. One word is pushed per cycle it is high.
- `up_data`  in  64  word from the aggregator.
- `tx_ready`  in  1  downstream accepts `tx_data` this cycle.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_data`  out  8  frame byte.
- `tx_last`  out  1  high with the checksum byte (last byte of the frame).
- `overflow`  out  1  sticky. A word was dropped because the buffer was full.
- `fill_level`  out  $clog2(DEPTH)+1  words currently buffered.

Behaviour:
- Reset (synchronous, `rst`=1 at a `fifo_rdclk` rising edge):
  - `tx_valid`=0, `tx_data`=0, `tx_last`=0, `overflow`=0, `fill_level`=0.
  - Sequence counter = 0, timeout counter = 0, FSM = IDLE.
  - Reset mid-frame aborts the frame immediately. No further bytes are sent and buffered words are discarded.
- Buffer:
  - Push on `data_valid`=1.
  - If `fill_level`==`DEPTH` at that edge, the word is dropped and `overflow` is set. This uses the pre-edge level, so the word is dropped even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave `fill_level` unchanged.
  - Pointers wrap modulo `DEPTH`.
- Byte transfer: a byte transfers when `tx_valid`&&`tx_ready`. While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_last` hold stable.
- FSM states: IDLE, SOF0, SOF1, LEN, SEQ, PAY, CHK.
- IDLE:
  - If `fill_level` ≥ `WORDS_PER_FRAME`: latch `len`=`WORDS_PER_FRAME` and go to SOF0. `tx_valid` rises on the next cycle.
  - Else if 0 < `fill_level` < `WORDS_PER_FRAME`: increment the timeout counter. When it reaches `TIMEOUT`-1, latch `len`=`fill_level` (pre-edge) and go to SOF0.
  - Else (`fill_level`=0): the timeout counter is held at 0.
  - The timeout counter clears on every frame start.
- Each state advances only on a byte transfer:
  - SOF0 emits 0xA5.
  - SOF1 emits 0x5A.
  - LEN emits `len`.
  - SEQ emits the sequence counter value.
  - PAY emits `len`×8 bytes: each word MSB byte first (`up_data[63:56]` … `[7:0]`), read from the FIFO head. The word is popped on transfer of its 8th byte.
  - CHK emits the checksum with `tx_last`=1, then returns to IDLE.
- Checksum: 8-bit sum, modulo 256, of the LEN byte, SEQ byte and all payload bytes. SOF bytes are excluded.
- Sequence counter: 8 bits. Increments on the CHK transfer and wraps 255→0.
- Words arriving during a frame stay buffered for later frames. `len` is fixed at frame start.
- Back-to-back frames: after CHK, IDLE evaluates on the next cycle. This gives a minimum of 1 idle cycle (`tx_valid`=0) between frames.

Test Plan:
- Full frame: `rst` then 4 pushes of 0x0102030405060708, `tx_ready`=1 constant.
  - Required stream: A5 5A 04 00, then (01..08)×4, then 94 with `tx_last`=1.
  - `fill_level` returns to 0 and SEQ becomes 1.
- Timeout short frame: 1 push of 0x00000000000000FF, `TIMEOUT`=1000.
  - `tx_valid` stays 0 for 1000 cycles after the push, then the stream is A5 5A 01 00 00×7 FF 00.
- Backpressure: full-frame stimulus with `tx_ready` toggling 1,0,0,1… every cycle.
  - Identical byte sequence to the full-frame case, no duplicate or lost bytes, and `tx_data` is stable during every stall.
- Overflow: `tx_ready`=0, 17 consecutive pushes with `DEPTH`=16.
  - `fill_level`=16 and `overflow`=1 after the 17th push.
  - Then raise `tx_ready`: 4 frames carry words 1..16 in order and word 17 never appears.
- Simultaneous push/pop: push on the exact cycle a payload word pops (its 8th byte transfers).
  - `fill_level` is unchanged that cycle and the pushed word appears in the next frame.
- Reset mid-frame: assert `rst` for 1 cycle during PAY of frame SEQ=5.
  - Next cycle: `tx_valid`=0, `fill_level`=0, `overflow`=0.
  - The next frame carries SEQ=00.

Source files
------------

// File: rtl/up_data_framer.sv
// up_data_framer
//   Buffers the aggregator's 64-bit word stream (no backpressure) in a word
//   FIFO and packs it into byte-serial frames for the upload link:
//     A5 5A LEN SEQ payload(LEN*8 bytes, MSB byte first) CHK
//   CHK is the 8-bit sum of LEN, SEQ and all payload bytes.
//   A short frame is forced when a partial buffer has waited TIMEOUT cycles.
//
// Ports
//   fifo_rdclk  clock for the whole block
//   rst         synchronous active-high reset
//   data_valid  pushes up_data into the word FIFO
//   up_data     64-bit input word
//   tx_ready    downstream accepts tx_data this cycle
//   tx_valid    tx_data valid
//   tx_data     frame byte
//   tx_last     marks the checksum byte
//   overflow    sticky, a word was dropped on a full buffer
//   fill_level  words currently buffered
module up_data_framer #(
  parameter int DEPTH           = 16,
  parameter int WORDS_PER_FRAME = 4,
  parameter int TIMEOUT         = 1000
) (
  input  logic                   fifo_rdclk,
  input  logic                   rst,
  input  logic                   data_valid,
  input  logic [63:0]            up_data,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_last,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int TO_W   = $clog2(TIMEOUT);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_WPF  = FILL_W'(WORDS_PER_FRAME);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [7:0]        LEN_FULL  = 8'(WORDS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF0 = 3'd1,
    S_SOF1 = 3'd2,
    S_LEN  = 3'd3,
    S_SEQ  = 3'd4,
    S_PAY  = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  // Advance a FIFO pointer with explicit wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Select byte idx of a word, idx 0 being the most significant byte.
  function automatic logic [7:0] byte_of(input logic [63:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return w[63:56];
      3'd1:    return w[55:48];
      3'd2:    return w[47:40];
      3'd3:    return w[39:32];
      3'd4:    return w[31:24];
      3'd5:    return w[23:16];
      3'd6:    return w[15:8];
      3'd7:    return w[7:0];
      default: return 8'h00;
    endcase
  endfunction

  logic [63:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d, seq_q, seq_d, csum_q, csum_d, word_q, word_d;
  logic [2:0]        byte_q, byte_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              xfer_s, push_s, pop_s;

  // Frame FSM, FIFO bookkeeping and next registered output byte.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    to_d    = to_q;
    byte_d  = byte_q;
    word_d  = word_q;
    pop_s   = 1'b0;
    xfer_s  = tx_valid_q & tx_ready;

    case (state_q)
      S_IDLE: begin
        csum_d = 8'h00;
        byte_d = 3'd0;
        word_d = 8'h00;
        if (fill_q >= FILL_WPF) begin
          len_d   = LEN_FULL;
          to_d    = {TO_W{1'b0}};
          state_d = S_SOF0;
        end else if (fill_q != {FILL_W{1'b0}}) begin
          if (to_q == TO_LAST) begin
            // fill_q < WORDS_PER_FRAME <= 255 here, so it fits in len
            len_d   = 8'(fill_q);
            to_d    = {TO_W{1'b0}};
            state_d = S_SOF0;
          end else begin
            to_d = to_q + TO_W'(1'b1);
          end
        end else begin
          to_d = {TO_W{1'b0}};
        end
      end
      S_SOF0: begin
        if (xfer_s) begin
          state_d = S_SOF1;
        end else begin
          state_d = S_SOF0;
        end
      end
      S_SOF1: begin
        if (xfer_s) begin
          state_d = S_LEN;
        end else begin
          state_d = S_SOF1;
        end
      end
      S_LEN, S_SEQ: begin
        if (xfer_s) begin
          csum_d  = csum_q + tx_data_q;
          state_d = (state_q == S_LEN) ? S_SEQ : S_PAY;
        end else begin
          csum_d = csum_q;
        end
      end
      S_PAY: begin
        if (xfer_s) begin
          csum_d = csum_q + tx_data_q;
          if (byte_q == 3'd7) begin
            // head word fully sent: release it from the FIFO
            pop_s  = 1'b1;
            byte_d = 3'd0;
            if (word_q == len_q - 8'd1) begin
              state_d = S_CHK;
            end else begin
              word_d = word_q + 8'd1;
            end
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end else begin
          csum_d = csum_q;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          seq_d   = seq_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Full test uses the pre-edge level, so a concurrent pop does not save the word.
    push_s     = data_valid & (fill_q != FILL_FULL);
    overflow_d = overflow_q | (data_valid & (fill_q == FILL_FULL));
    wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d     = fill_q + FILL_W'(push_s) - FILL_W'(pop_s);

    // Outputs are precomputed from next state so they come straight from flops.
    tx_valid_d = (state_d != S_IDLE);
    tx_last_d  = (state_d == S_CHK);
    case (state_d)
      S_SOF0:  tx_data_d = 8'hA5;
      S_SOF1:  tx_data_d = 8'h5A;
      S_LEN:   tx_data_d = len_d;
      S_SEQ:   tx_data_d = seq_d;
      S_PAY:   tx_data_d = byte_of(mem_q[rd_ptr_d], byte_d);
      S_CHK:   tx_data_d = csum_d;
      default: tx_data_d = 8'h00;
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge fifo_rdclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      fill_q     <= {FILL_W{1'b0}};
      overflow_q <= 1'b0;
      len_q      <= 8'h00;
      seq_q      <= 8'h00;
      csum_q     <= 8'h00;
      word_q     <= 8'h00;
      byte_q     <= 3'd0;
      to_q       <= {TO_W{1'b0}};
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      to_q       <= to_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  // Word storage; contents need no reset since the pointers define validity.
  always_ff @(posedge fifo_rdclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= up_data;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign overflow   = overflow_q;
  assign fill_level = fill_q;

endmodule
